// File: rtl/mini_mem_pkg.sv
// Types shared between the mini core and its data-memory responder:
// default bus widths, responder FSM states and request/response records.
package mini_mem_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } mem_rsp_t;

endpackage

// File: rtl/mini_dmem_array.sv
// Data RAM for the mini core: synchronous write, combinational read,
// every word cleared while reset is low.
module mini_dmem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  in_range;

  assign in_range = 32'(addr) < MEM_DEPTH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  // Unimplemented words read as zero so the index never leaves the array.
  assign rdata = in_range ? mem[addr] : '0;

endmodule

// File: rtl/mini_dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits
// WAIT_STATES cycles, performs the access and holds the response until taken.
module mini_dmem_responder
  import mini_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  state_t                state;
  state_t                state_next;
  logic [3:0]            count;
  logic [3:0]            count_next;
  mem_req_t              req_in;
  mem_req_t              req_q;
  mem_req_t              acc;
  mem_rsp_t              rsp_q;
  mem_rsp_t              rsp_next;
  logic                  accept;
  logic                  do_access;
  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign accept    = req_valid && req_ready;
  assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};

  // With no wait states the access lands on the accept edge itself, before
  // the request registers are loaded, so the live inputs are used there.
  always_comb begin
    acc = req_q;
    if (state == IDLE) begin
      acc = req_in;
    end
  end

  assign do_access = ((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (count == 4'd0));
  assign in_range  = 32'(acc.addr) < MEM_DEPTH;
  assign mem_we    = do_access && acc.we && in_range;

  mini_dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .addr (acc.addr),
    .wdata(acc.wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    rsp_next   = rsp_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            count_next = 4'(WAIT_STATES - 1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          state_next = RESP;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          rsp_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    // Stores and out-of-range accesses return zero data.
    if (do_access) begin
      rsp_next.err   = !in_range;
      rsp_next.rdata = (in_range && !acc.we) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      rsp_q <= rsp_next;
      if (accept) begin
        req_q <= req_in;
      end
    end
  end

endmodule

// File: tb/tb_mini_dmem_responder.sv
// Directed bench for mini_dmem_responder: three instances cover the default
// configuration, a 12-word RAM with an error region, and zero wait states.
module tb_mini_dmem_responder;

  localparam int NDUT = 3;
  localparam int WS_TAB    [NDUT] = '{2, 2, 0};
  localparam int DEPTH_TAB [NDUT] = '{16, 12, 16};

  logic        clk;
  logic        reset;
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [3:0]  req_addr  [NDUT];
  logic [15:0] req_wdata [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [15:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
  logic        busy      [NDUT];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mini_dmem_responder #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (4),
      .MEM_DEPTH  (DEPTH_TAB[g]),
      .WAIT_STATES(WS_TAB[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g]),
      .busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check_output({tag, ".rdy"},   32'(req_ready[d]), 32'd1);
    check_output({tag, ".valid"}, 32'(rsp_valid[d]), 32'd0);
    check_output({tag, ".busy"},  32'(busy[d]),      32'd0);
    check_output({tag, ".rdata"}, 32'(rsp_rdata[d]), 32'd0);
    check_output({tag, ".err"},   32'(rsp_err[d]),   32'd0);
  endtask

  // One complete transaction. After acceptance the request inputs are
  // scrambled into a store of 16'hDEAD to the complementary address, which
  // must never be sampled. hold = extra back-pressured cycles in RESP;
  // early = rsp_ready raised together with the request.
  task automatic apply_stimulus(input int d, input logic we, input logic [3:0] addr,
                                input logic [15:0] wdata, input int hold, input logic early,
                                input logic [15:0] exp_rdata, input logic exp_err,
                                input string tag);
    int lat;
    @(negedge clk);
    check_output({tag, ".rdy_idle"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = early;
    @(posedge clk);
    #1;
    req_we[d]    = 1'b1;
    req_addr[d]  = addr ^ 4'hF;
    req_wdata[d] = 16'hDEAD;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[d] && lat < 40);
    check_output({tag, ".lat"},   32'(lat),          32'(1 + WS_TAB[d]));
    check_output({tag, ".rdata"}, 32'(rsp_rdata[d]), 32'(exp_rdata));
    check_output({tag, ".err"},   32'(rsp_err[d]),   32'(exp_err));
    check_output({tag, ".busy"},  32'(busy[d]),      32'd1);
    check_output({tag, ".rdy"},   32'(req_ready[d]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_output($sformatf("%s.hold%0d.valid", tag, i), 32'(rsp_valid[d]), 32'd1);
      check_output($sformatf("%s.hold%0d.rdata", tag, i), 32'(rsp_rdata[d]), 32'(exp_rdata));
      check_output($sformatf("%s.hold%0d.rdy", tag, i),   32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    check_idle(d, {tag, ".after"});
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 4'd0;
      req_wdata[d] = 16'd0;
      rsp_ready[d] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_idle(d, $sformatf("rst_in%0d", d));
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_idle(d, $sformatf("rst_out%0d", d));

    // Freshly cleared RAM, and no error anywhere when every address is implemented.
    for (int a = 0; a < 16; a++) begin
      apply_stimulus(0, 1'b0, 4'(a), 16'h0, 0, 1'b0, 16'h0, 1'b0, $sformatf("ld0_%0d", a));
    end

    apply_stimulus(0, 1'b1, 4'd2, 16'd200, 0, 1'b0, 16'h0,   1'b0, "st2");
    apply_stimulus(0, 1'b0, 4'd2, 16'h0,   0, 1'b0, 16'd200, 1'b0, "ld2");
    apply_stimulus(0, 1'b1, 4'd1, 16'd100, 0, 1'b0, 16'h0,   1'b0, "st1");
    apply_stimulus(0, 1'b0, 4'd1, 16'h0,   5, 1'b0, 16'd100, 1'b0, "bp_ld1");
    apply_stimulus(0, 1'b0, 4'd2, 16'h0,   0, 1'b1, 16'd200, 1'b0, "early_ld2");
    apply_stimulus(0, 1'b0, 4'd13, 16'h0,  0, 1'b0, 16'h0,   1'b0, "ld13_untouched");

    apply_stimulus(1, 1'b1, 4'd11, 16'h1111, 0, 1'b0, 16'h0, 1'b0, "e_st11");
    apply_stimulus(1, 1'b1, 4'd13, 16'hABCD, 0, 1'b0, 16'h0, 1'b1, "e_st13");
    apply_stimulus(1, 1'b0, 4'd12, 16'h0,    0, 1'b0, 16'h0, 1'b1, "e_ld12");
    for (int a = 0; a < 12; a++) begin
      apply_stimulus(1, 1'b0, 4'(a), 16'h0, 0, 1'b0, (a == 11) ? 16'h1111 : 16'h0, 1'b0,
                     $sformatf("e_ld%0d", a));
    end

    apply_stimulus(2, 1'b1, 4'd3,  16'h5A5A, 0, 1'b0, 16'h0,    1'b0, "z_st3");
    apply_stimulus(2, 1'b0, 4'd3,  16'h0,    0, 1'b0, 16'h5A5A, 1'b0, "z_ld3");
    apply_stimulus(2, 1'b0, 4'd12, 16'h0,    2, 1'b0, 16'h0,    1'b0, "z_ld12");

    // Reset in the middle of a store's wait period.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 4'd5;
    req_wdata[0] = 16'd7;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check_output("mid.busy", 32'(busy[0]), 32'd1);
    reset = 1'b0;
    #1;
    check_output("mid.rst.busy", 32'(busy[0]),      32'd0);
    check_output("mid.rst.rdy",  32'(req_ready[0]), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output($sformatf("mid.novalid%0d", i), 32'(rsp_valid[0]), 32'd0);
    end
    rsp_ready[0] = 1'b0;
    apply_stimulus(0, 1'b0, 4'd5,  16'h0, 0, 1'b0, 16'h0, 1'b0, "mid.ld5");
    apply_stimulus(0, 1'b0, 4'd2,  16'h0, 0, 1'b0, 16'h0, 1'b0, "mid.ld2");
    apply_stimulus(1, 1'b0, 4'd11, 16'h0, 0, 1'b0, 16'h0, 1'b0, "mid.e_ld11");
    apply_stimulus(2, 1'b0, 4'd3,  16'h0, 0, 1'b0, 16'h0, 1'b0, "mid.z_ld3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
